// File: rtl/mul_fifo_pkg.sv
// ----------------------------------------------------------------------------
// mul_fifo_pkg
// Shared constants and types for the multiplier-FIFO read-side checker.
//   OP_W   : width of each reference operand (a, b)
//   DATA_W : product width, 2*OP_W, so a*b never truncates
//   WORDS  : number of products in one full run, every {a,b} combination once
//   rd_state_t : reader FSM state encoding
// ----------------------------------------------------------------------------
package mul_fifo_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 2 * OP_W;
    localparam int WORDS  = 2 ** (2 * OP_W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LATCH = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } rd_state_t;

endpackage : mul_fifo_pkg

// File: rtl/mul_ref_gen.sv
// ----------------------------------------------------------------------------
// mul_ref_gen
// Reference generator for the FIFO checker: a {a,b} counter that starts at 0
// and steps once per checked word, plus the full-width unsigned product a*b.
// Ports:
//   Rclk   in   read-domain clock
//   Rrst   in   synchronous active-high reset, clears {a,b}
//   adv_i  in   advance {a,b} by one (wraps from all-ones to 0)
//   exp_o  out  DATA_W expected product a*b for the current counter value
// ----------------------------------------------------------------------------
module mul_ref_gen #(
    parameter int OP_W   = mul_fifo_pkg::OP_W,
    parameter int DATA_W = mul_fifo_pkg::DATA_W
) (
    input  logic              Rclk,
    input  logic              Rrst,
    input  logic              adv_i,
    output logic [DATA_W-1:0] exp_o
);

    import mul_fifo_pkg::*;

    logic [2*OP_W-1:0] ab_q;
    logic [2*OP_W-1:0] ab_d;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;

    // a is the upper half, so b runs fastest: 0*0, 0*1, ..., 0*15, 1*0, ...
    assign a = ab_q[2*OP_W-1:OP_W];
    assign b = ab_q[OP_W-1:0];

    always_comb begin
        ab_d = ab_q;
        if (adv_i) begin
            ab_d = ab_q + 1'b1;
        end
    end

    always_ff @(posedge Rclk) begin
        if (Rrst) begin
            ab_q <= '0;
        end else begin
            ab_q <= ab_d;
        end
    end

    // Operands are widened before the multiply so the product keeps all bits.
    assign exp_o = DATA_W'(a) * DATA_W'(b);

endmodule : mul_ref_gen

// File: rtl/mul_fifo_reader.sv
// ----------------------------------------------------------------------------
// mul_fifo_reader
// Read side of a multiplier-result FIFO. Pops one word at a time, compares it
// against a locally generated a*b sequence and reports the result. One word
// takes at least four cycles: IDLE -> POP -> LATCH -> CHECK.
// Ports:
//   Rclk      in   read-domain clock (rising edge)
//   Rrst      in   synchronous active-high reset
//   Enable_i  in   allows a new pop to start from IDLE
//   Rempty_i  in   FIFO empty flag
//   Rdata_i   in   FIFO read data, valid the cycle after Rinc_o
//   Rinc_o    out  FIFO pop strobe (high only in POP)
//   Prod_o    out  last checked word
//   Valid_o   out  one-cycle pulse when Prod_o updates
//   Err_o     out  sticky mismatch flag
//   ErrCnt_o  out  mismatch count, saturates at 255
//   Count_o   out  number of words checked
//   Done_o    out  sticky, set once WORDS words are checked
// ----------------------------------------------------------------------------
module mul_fifo_reader #(
    parameter int DATA_W = mul_fifo_pkg::DATA_W,
    parameter int OP_W   = mul_fifo_pkg::OP_W,
    parameter int WORDS  = mul_fifo_pkg::WORDS
) (
    input  logic              Rclk,
    input  logic              Rrst,
    input  logic              Enable_i,
    input  logic              Rempty_i,
    input  logic [DATA_W-1:0] Rdata_i,
    output logic              Rinc_o,
    output logic [DATA_W-1:0] Prod_o,
    output logic              Valid_o,
    output logic              Err_o,
    output logic [7:0]        ErrCnt_o,
    output logic [8:0]        Count_o,
    output logic              Done_o
);

    import mul_fifo_pkg::*;

    rd_state_t         state_q;
    rd_state_t         state_d;

    logic [DATA_W-1:0] cap_q;
    logic [DATA_W-1:0] cap_d;
    logic [DATA_W-1:0] prod_q;
    logic [DATA_W-1:0] prod_d;
    logic              valid_q;
    logic              valid_d;
    logic              err_q;
    logic              err_d;
    logic [7:0]        errcnt_q;
    logic [7:0]        errcnt_d;
    logic [8:0]        count_q;
    logic [8:0]        count_d;
    logic              done_q;
    logic              done_d;

    logic [DATA_W-1:0] exp_val;
    logic              ref_adv;
    logic [8:0]        count_inc;
    logic              last_word;
    logic              mismatch;

    assign ref_adv   = (state_q == CHECK);
    assign count_inc = count_q + 9'd1;
    assign last_word = (count_inc == 9'(WORDS));
    assign mismatch  = (cap_q != exp_val);

    mul_ref_gen #(
        .OP_W   (OP_W),
        .DATA_W (DATA_W)
    ) u_ref_gen (
        .Rclk  (Rclk),
        .Rrst  (Rrst),
        .adv_i (ref_adv),
        .exp_o (exp_val)
    );

    // State register
    always_ff @(posedge Rclk) begin
        if (Rrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Enable_i and Rempty_i matter only in IDLE: once a pop
    // is committed the word always runs through LATCH and CHECK.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (Enable_i && !Rempty_i) begin
                    state_d = POP;
                end
            end
            POP:     state_d = LATCH;
            LATCH:   state_d = CHECK;
            CHECK:   state_d = last_word ? DONE : IDLE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: the pop strobe is the only combinational output.
    always_comb begin
        Rinc_o = (state_q == POP);
    end

    // Datapath next values; everything holds unless the state acts on it,
    // which also freezes all outputs once DONE is reached.
    always_comb begin
        cap_d    = cap_q;
        prod_d   = prod_q;
        valid_d  = 1'b0;
        err_d    = err_q;
        errcnt_d = errcnt_q;
        count_d  = count_q;
        done_d   = done_q;
        case (state_q)
            LATCH: begin
                cap_d = Rdata_i;
            end
            CHECK: begin
                prod_d  = cap_q;
                valid_d = 1'b1;
                count_d = count_inc;
                if (mismatch) begin
                    err_d = 1'b1;
                    if (errcnt_q != 8'hFF) begin
                        errcnt_d = errcnt_q + 8'd1;
                    end
                end
                // Raised together with the final Valid_o pulse.
                if (last_word) begin
                    done_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Rclk) begin
        if (Rrst) begin
            cap_q    <= '0;
            prod_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            cap_q    <= cap_d;
            prod_q   <= prod_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    assign Prod_o   = prod_q;
    assign Valid_o  = valid_q;
    assign Err_o    = err_q;
    assign ErrCnt_o = errcnt_q;
    assign Count_o  = count_q;
    assign Done_o   = done_q;

endmodule : mul_fifo_reader

// File: tb/tb_mul_fifo_reader.sv
// ----------------------------------------------------------------------------
// tb_mul_fifo_reader
// Bench for mul_fifo_reader: a simple FIFO model feeds words, a negedge
// monitor records what the reader reports, and scenario tasks compare that
// record against products computed directly as (i/16)*(i%16).
// ----------------------------------------------------------------------------
module tb_mul_fifo_reader;

    logic       Rclk;
    logic       Rrst;
    logic       Enable_i;
    logic       Rempty_i;
    logic       Rinc_o;
    logic [7:0] Prod_o;
    logic       Valid_o;
    logic       Err_o;
    logic [7:0] ErrCnt_o;
    logic [8:0] Count_o;
    logic       Done_o;

    // FIFO model: mem holds the run, wr_ptr is how much the writer has made
    // visible so far, rd_ptr advances on each pop.
    logic [7:0] mem [0:255];
    int         wr_ptr;
    int         wr_limit;
    int         rd_ptr;
    logic [7:0] rdata_q;
    logic       force_empty;
    logic       fifo_clr;

    // Monitor record
    logic       mon_clr;
    int         valid_cnt;
    int         rinc_cnt;
    int         rinc_empty_viol;
    int         rinc_after_done;
    int         err_first_idx;
    logic [7:0] got_prod [0:255];

    int n_checks;
    int n_fail;

    mul_fifo_reader #(
        .DATA_W (8),
        .OP_W   (4),
        .WORDS  (256)
    ) dut (
        .Rclk     (Rclk),
        .Rrst     (Rrst),
        .Enable_i (Enable_i),
        .Rempty_i (Rempty_i),
        .Rdata_i  (rdata_q),
        .Rinc_o   (Rinc_o),
        .Prod_o   (Prod_o),
        .Valid_o  (Valid_o),
        .Err_o    (Err_o),
        .ErrCnt_o (ErrCnt_o),
        .Count_o  (Count_o),
        .Done_o   (Done_o)
    );

    initial Rclk = 1'b0;
    always #5 Rclk = ~Rclk;

    assign Rempty_i = force_empty | (rd_ptr >= wr_ptr);

    always @(posedge Rclk) begin
        if (fifo_clr) begin
            rd_ptr  <= 0;
            rdata_q <= '0;
        end else if (Rinc_o) begin
            rdata_q <= mem[rd_ptr % 256];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    always @(negedge Rclk) begin
        if (mon_clr) begin
            valid_cnt       <= 0;
            rinc_cnt        <= 0;
            rinc_empty_viol <= 0;
            rinc_after_done <= 0;
            err_first_idx   <= -1;
        end else begin
            if (Valid_o) begin
                got_prod[valid_cnt % 256] <= Prod_o;
                valid_cnt <= valid_cnt + 1;
                if (Err_o && err_first_idx < 0) err_first_idx <= valid_cnt;
            end
            if (Rinc_o) begin
                rinc_cnt <= rinc_cnt + 1;
                if (Rempty_i) rinc_empty_viol <= rinc_empty_viol + 1;
                if (Done_o)   rinc_after_done <= rinc_after_done + 1;
            end
        end
    end

    // Reference: the i-th word of a run is (i/16)*(i%16).
    function automatic logic [7:0] model_prod(input int i);
        int a;
        int b;
        a = (i / 16) % 16;
        b = i % 16;
        return 8'(a * b);
    endfunction

    // kind 0: correct, 1: word 17 -> 0x02, 2: all wrong, 3: random corruption
    task automatic load_words(input int kind, input bit trickle);
        logic [7:0] e;
        for (int i = 0; i < 256; i++) begin
            e = model_prod(i);
            case (kind)
                1:       mem[i] = (i == 17) ? 8'h02 : e;
                2:       mem[i] = e ^ 8'h80;
                3:       mem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : e;
                default: mem[i] = e;
            endcase
        end
        wr_limit = 256;
        wr_ptr   = trickle ? 0 : 256;
    endtask

    task automatic do_reset();
        Rrst        = 1'b1;
        Enable_i    = 1'b0;
        force_empty = 1'b0;
        fifo_clr    = 1'b1;
        mon_clr     = 1'b1;
        wr_ptr      = 0;
        wr_limit    = 0;
        repeat (2) @(posedge Rclk);
        #1;
        fifo_clr = 1'b0;
        mon_clr  = 1'b0;
        Rrst     = 1'b0;
    endtask

    // Bounded wait until target Valid_o pulses have been seen.
    task automatic run_until(input int target, input int budget, input bit rnd_en, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge Rclk);
            #1;
            if (wr_ptr < wr_limit && $urandom_range(0, 1) == 1) wr_ptr++;
            if (rnd_en) Enable_i = ($urandom_range(0, 3) != 0);
            if (valid_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (Prod_o !== 8'h00)   begin n_fail++; $display("FAIL reset_prod: got %h expected 00", Prod_o); end
        n_checks++; if (Valid_o !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b expected 0", Valid_o); end
        n_checks++; if (Err_o !== 1'b0)     begin n_fail++; $display("FAIL reset_err: got %b expected 0", Err_o); end
        n_checks++; if (ErrCnt_o !== 8'd0)  begin n_fail++; $display("FAIL reset_errcnt: got %0d expected 0", ErrCnt_o); end
        n_checks++; if (Count_o !== 9'd0)   begin n_fail++; $display("FAIL reset_count: got %0d expected 0", Count_o); end
        n_checks++; if (Done_o !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b expected 0", Done_o); end
        n_checks++; if (Rinc_o !== 1'b0)    begin n_fail++; $display("FAIL reset_rinc: got %b expected 0", Rinc_o); end
    endtask

    task automatic test_full_run();
        bit ok;
        do_reset();
        load_words(0, 1'b1);
        Enable_i = 1'b1;
        run_until(256, 8000, 1'b1, ok);
        Enable_i = 1'b1;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_timeout: got %0d valids expected 256", valid_cnt); end
        repeat (20) @(posedge Rclk);
        #1;
        n_checks++; if (valid_cnt != 256)   begin n_fail++; $display("FAIL full_valids: got %0d expected 256", valid_cnt); end
        n_checks++; if (rinc_cnt != 256)    begin n_fail++; $display("FAIL full_pops: got %0d expected 256", rinc_cnt); end
        n_checks++; if (Err_o !== 1'b0)     begin n_fail++; $display("FAIL full_err: got %b expected 0", Err_o); end
        n_checks++; if (ErrCnt_o !== 8'd0)  begin n_fail++; $display("FAIL full_errcnt: got %0d expected 0", ErrCnt_o); end
        n_checks++; if (Count_o !== 9'd256) begin n_fail++; $display("FAIL full_count: got %0d expected 256", Count_o); end
        n_checks++; if (Done_o !== 1'b1)    begin n_fail++; $display("FAIL full_done: got %b expected 1", Done_o); end
        n_checks++; if (rinc_after_done != 0) begin n_fail++; $display("FAIL full_rinc_after_done: got %0d expected 0", rinc_after_done); end
        n_checks++; if (rinc_empty_viol != 0) begin n_fail++; $display("FAIL full_rinc_when_empty: got %0d expected 0", rinc_empty_viol); end
        for (int i = 0; i < 256; i++) begin
            n_checks++;
            if (got_prod[i] !== model_prod(i)) begin
                n_fail++;
                $display("FAIL full_prod[%0d]: got %h expected %h", i, got_prod[i], model_prod(i));
            end
        end
    endtask

    task automatic test_corrupt_word17();
        bit ok;
        do_reset();
        load_words(1, 1'b0);
        Enable_i = 1'b1;
        run_until(256, 2000, 1'b0, ok);
        repeat (3) @(posedge Rclk);
        #1;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL c17_timeout: got %0d valids expected 256", valid_cnt); end
        n_checks++; if (err_first_idx != 17) begin n_fail++; $display("FAIL c17_err_rise_word: got %0d expected 17", err_first_idx); end
        n_checks++; if (got_prod[17] !== 8'h02) begin n_fail++; $display("FAIL c17_prod: got %h expected 02", got_prod[17]); end
        n_checks++; if (ErrCnt_o !== 8'd1)  begin n_fail++; $display("FAIL c17_errcnt: got %0d expected 1", ErrCnt_o); end
        n_checks++; if (Err_o !== 1'b1)     begin n_fail++; $display("FAIL c17_err: got %b expected 1", Err_o); end
        n_checks++; if (Count_o !== 9'd256) begin n_fail++; $display("FAIL c17_count: got %0d expected 256", Count_o); end
        n_checks++; if (Done_o !== 1'b1)    begin n_fail++; $display("FAIL c17_done: got %b expected 1", Done_o); end
    endtask

    task automatic test_empty_hold();
        do_reset();
        load_words(0, 1'b0);
        force_empty = 1'b1;
        Enable_i    = 1'b1;
        repeat (20) @(posedge Rclk);
        #1;
        n_checks++; if (rinc_cnt != 0)    begin n_fail++; $display("FAIL empty_no_pop: got %0d pops expected 0", rinc_cnt); end
        n_checks++; if (Count_o !== 9'd0) begin n_fail++; $display("FAIL empty_count: got %0d expected 0", Count_o); end
        force_empty = 1'b0;
        @(posedge Rclk);
        #1;
        n_checks++; if (Rinc_o !== 1'b1)  begin n_fail++; $display("FAIL empty_first_pop: got %b expected 1", Rinc_o); end
    endtask

    task automatic test_enable_drop();
        bit found;
        do_reset();
        load_words(0, 1'b0);
        Enable_i = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge Rclk);
            #1;
            if (Rinc_o) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL endrop_first_pop: got none expected a pop"); end
        @(posedge Rclk);
        #1;
        Enable_i = 1'b0;
        repeat (20) @(posedge Rclk);
        #1;
        n_checks++; if (valid_cnt != 1)   begin n_fail++; $display("FAIL endrop_valids: got %0d expected 1", valid_cnt); end
        n_checks++; if (rinc_cnt != 1)    begin n_fail++; $display("FAIL endrop_pops: got %0d expected 1", rinc_cnt); end
        n_checks++; if (Count_o !== 9'd1) begin n_fail++; $display("FAIL endrop_count: got %0d expected 1", Count_o); end
        Enable_i = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge Rclk);
            #1;
            if (Rinc_o) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL endrop_resume: got no pop expected pop"); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit found;
        do_reset();
        load_words(0, 1'b0);
        Enable_i = 1'b1;
        run_until(5, 200, 1'b0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_timeout: got %0d valids expected 5", valid_cnt); end
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (Rinc_o) begin
                found = 1'b1;
                break;
            end
            @(posedge Rclk);
            #1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL rmid_pop6: got none expected a pop"); end
        @(posedge Rclk);
        #1;
        Rrst = 1'b1;
        @(posedge Rclk);
        #1;
        n_checks++; if (Prod_o !== 8'h00)   begin n_fail++; $display("FAIL rmid_prod: got %h expected 00", Prod_o); end
        n_checks++; if (Valid_o !== 1'b0)   begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", Valid_o); end
        n_checks++; if (Err_o !== 1'b0)     begin n_fail++; $display("FAIL rmid_err: got %b expected 0", Err_o); end
        n_checks++; if (ErrCnt_o !== 8'd0)  begin n_fail++; $display("FAIL rmid_errcnt: got %0d expected 0", ErrCnt_o); end
        n_checks++; if (Count_o !== 9'd0)   begin n_fail++; $display("FAIL rmid_count: got %0d expected 0", Count_o); end
        n_checks++; if (Done_o !== 1'b0)    begin n_fail++; $display("FAIL rmid_done: got %b expected 0", Done_o); end
        n_checks++; if (Rinc_o !== 1'b0)    begin n_fail++; $display("FAIL rmid_rinc: got %b expected 0", Rinc_o); end
        fifo_clr = 1'b1;
        mon_clr  = 1'b1;
        wr_ptr   = 0;
        @(posedge Rclk);
        #1;
        fifo_clr = 1'b0;
        mon_clr  = 1'b0;
        load_words(0, 1'b0);
        Rrst = 1'b0;
        run_until(40, 400, 1'b0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_restart_timeout: got %0d valids expected 40", valid_cnt); end
        n_checks++; if (Err_o !== 1'b0)     begin n_fail++; $display("FAIL rmid_restart_err: got %b expected 0", Err_o); end
        n_checks++; if (Count_o !== 9'd40)  begin n_fail++; $display("FAIL rmid_restart_count: got %0d expected 40", Count_o); end
        n_checks++; if (got_prod[39] !== model_prod(39)) begin n_fail++; $display("FAIL rmid_restart_prod39: got %h expected %h", got_prod[39], model_prod(39)); end
    endtask

    task automatic test_all_wrong();
        bit ok;
        do_reset();
        load_words(2, 1'b0);
        Enable_i = 1'b1;
        run_until(256, 2000, 1'b0, ok);
        repeat (3) @(posedge Rclk);
        #1;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL allwrong_timeout: got %0d valids expected 256", valid_cnt); end
        n_checks++; if (ErrCnt_o !== 8'd255) begin n_fail++; $display("FAIL allwrong_errcnt: got %0d expected 255", ErrCnt_o); end
        n_checks++; if (Err_o !== 1'b1)      begin n_fail++; $display("FAIL allwrong_err: got %b expected 1", Err_o); end
        n_checks++; if (Done_o !== 1'b1)     begin n_fail++; $display("FAIL allwrong_done: got %b expected 1", Done_o); end
        n_checks++; if (Count_o !== 9'd256)  begin n_fail++; $display("FAIL allwrong_count: got %0d expected 256", Count_o); end
    endtask

    task automatic test_random_errors();
        bit ok;
        int errs;
        int exp_cnt;
        do_reset();
        load_words(3, 1'b1);
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] != model_prod(i)) errs++;
        end
        exp_cnt = (errs > 255) ? 255 : errs;
        Enable_i = 1'b1;
        run_until(256, 8000, 1'b1, ok);
        Enable_i = 1'b1;
        repeat (10) @(posedge Rclk);
        #1;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rnd_timeout: got %0d valids expected 256", valid_cnt); end
        n_checks++; if (ErrCnt_o !== 8'(exp_cnt)) begin n_fail++; $display("FAIL rnd_errcnt: got %0d expected %0d", ErrCnt_o, exp_cnt); end
        n_checks++; if (Err_o !== (errs > 0))     begin n_fail++; $display("FAIL rnd_err: got %b expected %b", Err_o, (errs > 0)); end
        n_checks++; if (Count_o !== 9'd256)       begin n_fail++; $display("FAIL rnd_count: got %0d expected 256", Count_o); end
        n_checks++; if (Done_o !== 1'b1)          begin n_fail++; $display("FAIL rnd_done: got %b expected 1", Done_o); end
        n_checks++; if (rinc_empty_viol != 0)     begin n_fail++; $display("FAIL rnd_rinc_when_empty: got %0d expected 0", rinc_empty_viol); end
        for (int i = 0; i < 256; i++) begin
            n_checks++;
            if (got_prod[i] !== mem[i]) begin
                n_fail++;
                $display("FAIL rnd_prod[%0d]: got %h expected %h", i, got_prod[i], mem[i]);
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        Rrst        = 1'b1;
        Enable_i    = 1'b0;
        force_empty = 1'b0;
        fifo_clr    = 1'b1;
        mon_clr     = 1'b1;
        wr_ptr      = 0;
        wr_limit    = 0;
        test_reset();
        test_full_run();
        test_corrupt_word17();
        test_empty_hold();
        test_enable_drop();
        test_reset_mid();
        test_all_wrong();
        test_random_errors();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mul_fifo_reader
